// File: rtl/btc_wb_host_if.sv
// Wishbone bus between the job host (master) and the miner's slave port.
// Master drives the request side; the slave returns read data and acknowledge.
`timescale 1ns/1ps
interface btc_wb_host_if #(
  parameter int BITS = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [3:0]      sel;
  logic [BITS-1:0] adr;
  logic [BITS-1:0] dat_w;
  logic [BITS-1:0] dat_r;
  logic            ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/btc_wb_host.sv
// Wishbone initiator that writes one mining job (header, target, start word) into
// the miner, waits for its result flag and reads the hash back.
`timescale 1ns/1ps
module btc_wb_host #(
  parameter int              BITS        = 32,
  parameter logic [BITS-1:0] BASE_ADDR   = 32'h3000_0000,
  parameter int              N_HDR       = 18,
  parameter int              N_HASH      = 8,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start_i,
  input  logic [N_HDR*BITS-1:0]    header_i,
  input  logic [BITS-1:0]          target_i,
  input  logic                     result_rdy_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [N_HASH*BITS-1:0]   hash_o,
  btc_wb_host_if.master            wbm
);

  localparam int KW = $clog2(N_HDR + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KW-1:0] K_LAST_WR = KW'(N_HDR + 1);
  localparam logic [KW-1:0] K_LAST_RD = KW'(N_HASH - 1);
  localparam logic [KW-1:0] K_TARGET  = KW'(N_HDR);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_REQ   = 3'd1,
    WR_GAP   = 3'd2,
    WAIT_RES = 3'd3,
    RD_REQ   = 3'd4,
    RD_GAP   = 3'd5,
    DONE     = 3'd6
  } state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [TW-1:0]            to_q, to_d;
  logic                     cyc_q, cyc_d;
  logic                     we_q, we_d;
  logic [3:0]               sel_q, sel_d;
  logic [BITS-1:0]          adr_q, adr_d;
  logic [BITS-1:0]          dat_q, dat_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [N_HASH*BITS-1:0]   hash_q, hash_d;
  logic                     to_hit_s;

  function automatic logic [BITS-1:0] word_addr(input logic [KW-1:0] k);
    return BASE_ADDR + BITS'({k, 2'b00});
  endfunction

  // Word k of the job: header words, then the encoded target, then the start command.
  function automatic logic [BITS-1:0] job_word(input logic [KW-1:0]         k,
                                               input logic [N_HDR*BITS-1:0] hdr,
                                               input logic [BITS-1:0]       tgt);
    logic [BITS-1:0] w;
    if (k < K_TARGET) begin
      w = hdr[BITS*k +: BITS];
    end else if (k == K_TARGET) begin
      w = tgt;
    end else begin
      w = {{(BITS-1){1'b0}}, 1'b1};
    end
    return w;
  endfunction

  assign to_hit_s = (to_q == TO_LIMIT);

  // Next-state and next-output logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    to_d    = to_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    hash_d  = hash_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          busy_d  = 1'b1;
          k_d     = '0;
          to_d    = '0;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = word_addr('0);
          dat_d   = job_word('0, header_i, target_i);
          state_d = WR_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (wbm.ack) begin
          cyc_d   = 1'b0;
          to_d    = '0;
          state_d = WR_GAP;
        end else if (to_hit_s) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          k_d     = '0;
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      WR_GAP: begin
        if (k_q < K_LAST_WR) begin
          k_d     = k_q + 1'b1;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = word_addr(k_q + 1'b1);
          dat_d   = job_word(k_q + 1'b1, header_i, target_i);
          state_d = WR_REQ;
        end else begin
          k_d     = '0;
          we_d    = 1'b0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (result_rdy_i) begin
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = word_addr(k_q);
          dat_d   = '0;
          state_d = RD_REQ;
        end else begin
          state_d = WAIT_RES;
        end
      end
      RD_REQ: begin
        if (wbm.ack) begin
          hash_d[BITS*k_q +: BITS] = wbm.dat_r;
          cyc_d   = 1'b0;
          to_d    = '0;
          state_d = RD_GAP;
        end else if (to_hit_s) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          k_d     = '0;
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RD_GAP: begin
        if (k_q < K_LAST_RD) begin
          k_d     = k_q + 1'b1;
          cyc_d   = 1'b1;
          adr_d   = word_addr(k_q + 1'b1);
          state_d = RD_REQ;
        end else begin
          k_d     = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sel_d = cyc_d ? 4'hF : 4'h0;
  end

  // State and registered bus/status outputs; reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      to_q    <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hash_q  <= hash_d;
    end
  end

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = we_q;
  assign wbm.sel   = sel_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = dat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign hash_o    = hash_q;

endmodule

// File: tb/tb_btc_wb_host.sv
// Bench for btc_wb_host: slave model with wait states / withheld ack, and a
// transfer scoreboard filled at job start and drained by a bus monitor.
`timescale 1ns/1ps
module tb_btc_wb_host;
  localparam int          BITS   = 32;
  localparam int          N_HDR  = 18;
  localparam int          N_HASH = 8;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  logic                   wb_clk_i = 1'b0;
  logic                   wb_rst_i = 1'b1;
  logic                   start_i = 1'b0;
  logic                   result_rdy_i = 1'b0;
  logic [N_HDR*BITS-1:0]  header_i = '0;
  logic [BITS-1:0]        target_i = '0;
  logic                   busy_o, done_o, err_o;
  logic [N_HASH*BITS-1:0] hash_o;

  int    n_vec = 0, n_err = 0, n_xfer = 0, done_cnt = 0, gap_viol = 0;
  int    wait_states = 0, wcnt = 0;
  logic  nack_en = 1'b0, stray_ack = 1'b0;
  xfer_t exp_q[$];
  logic [N_HASH*BITS-1:0] exp_hash;

  btc_wb_host_if #(.BITS(BITS)) bus ();

  btc_wb_host dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .start_i      (start_i),
    .header_i     (header_i),
    .target_i     (target_i),
    .result_rdy_i (result_rdy_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .hash_o       (hash_o),
    .wbm          (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Slave: ack after wait_states stalled cycles; word 5 can be left unacked.
  always @(posedge wb_clk_i) begin
    if (bus.stb && !bus.ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end
  assign bus.ack   = (bus.stb && (wcnt == wait_states) && !(nack_en && bus.adr == BASE + 32'd20)) || stray_ack;
  assign bus.dat_r = 32'h0000_00D0 + ((bus.adr - BASE) >> 2);

  initial begin
    for (int k = 0; k < N_HASH; k++) exp_hash[32*k +: 32] = 32'h0000_00D0 + 32'(k);
  end

  task automatic monitor_loop();
    xfer_t e;
    logic  prev_ack = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      if (wb_rst_i) begin
        prev_ack = 1'b0;
      end else begin
        if (bus.stb && prev_ack) gap_viol++;
        if (done_o) done_cnt++;
        if (bus.stb && bus.ack) begin
          n_vec++;
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL xfer_unexpected: got we=%0b adr=%h, required no transfer", bus.we, bus.adr);
          end else begin
            e = exp_q.pop_front();
            if (bus.we !== e.we || bus.adr !== e.adr || bus.sel !== 4'hF || bus.cyc !== 1'b1 ||
                (e.we && bus.dat_w !== e.dat)) begin
              n_err++;
              $display("FAIL xfer: got we=%0b adr=%h dat=%h sel=%h cyc=%0b, required we=%0b adr=%h dat=%h sel=f cyc=1",
                       bus.we, bus.adr, bus.dat_w, bus.sel, bus.cyc, e.we, e.adr, e.dat);
            end
          end
        end
        prev_ack = bus.stb && bus.ack;
      end
    end
  endtask

  task automatic push_job(input int n_wr, input int n_rd);
    xfer_t x;
    for (int k = 0; k < n_wr; k++) begin
      x.we  = 1'b1;
      x.adr = BASE + 32'(4*k);
      if (k < N_HDR)       x.dat = header_i[32*k +: 32];
      else if (k == N_HDR) x.dat = target_i;
      else                 x.dat = 32'h0000_0001;
      exp_q.push_back(x);
    end
    for (int k = 0; k < n_rd; k++) begin
      x.we  = 1'b0;
      x.adr = BASE + 32'(4*k);
      x.dat = 32'h0;
      exp_q.push_back(x);
    end
  endtask

  task automatic set_job(input logic rnd);
    for (int k = 0; k < N_HDR; k++)
      header_i[32*k +: 32] = rnd ? $urandom : (32'hA000_0000 + 32'(k));
    target_i = rnd ? $urandom : 32'h1703_A30C;
  endtask

  task automatic pulse_start();
    @(negedge wb_clk_i); start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
  endtask

  // Cycles from the first write strobe to the gap after the 20th write.
  task automatic measure_writes(input int x0, output int cycles);
    cycles = -1;
    for (int i = 0; i < 10 && !bus.stb; i++) @(negedge wb_clk_i);
    for (int i = 1; i < 1000; i++) begin
      if (n_xfer == x0 + 20 && !bus.stb) begin cycles = i; break; end
      @(negedge wb_clk_i);
    end
  endtask

  task automatic wait_done(output logic seen, output logic busy_at_done);
    seen = 1'b0; busy_at_done = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge wb_clk_i);
      if (done_o) begin seen = 1'b1; busy_at_done = busy_o; break; end
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    n_vec++; if ({bus.cyc, bus.stb, bus.we, bus.sel} !== 7'h0) begin n_err++; $display("FAIL reset_bus: got %b required 0000000", {bus.cyc, bus.stb, bus.we, bus.sel}); end
    n_vec++; if ({bus.adr, bus.dat_w} !== 64'h0) begin n_err++; $display("FAIL reset_adr_dat: got %h required 0", {bus.adr, bus.dat_w}); end
    n_vec++; if ({busy_o, done_o, err_o} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b required 000", {busy_o, done_o, err_o}); end
    n_vec++; if (hash_o !== '0) begin n_err++; $display("FAIL reset_hash: got %h required 0", hash_o); end
  endtask

  task automatic test_write_read();
    int x0, d0, cycles; logic seen, bd;
    wait_states = 0; set_job(1'b0); push_job(20, 8);
    x0 = n_xfer; d0 = done_cnt;
    pulse_start();
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b required 1", busy_o); end
    measure_writes(x0, cycles);
    n_vec++; if (cycles != 40) begin n_err++; $display("FAIL wr_cycles: got %0d required 40", cycles); end
    repeat (100) @(negedge wb_clk_i);
    n_vec++; if (n_xfer - x0 != 20) begin n_err++; $display("FAIL wait_res_idle: got %0d transfers required 20", n_xfer - x0); end
    result_rdy_i = 1'b1;
    wait_done(seen, bd);
    result_rdy_i = 1'b0;
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rd_done: got %b required 1", seen); end
    n_vec++; if (bd !== 1'b0) begin n_err++; $display("FAIL rd_busy_at_done: got %b required 0", bd); end
    n_vec++; if (hash_o !== exp_hash) begin n_err++; $display("FAIL rd_hash: got %h required %h", hash_o, exp_hash); end
    repeat (5) @(negedge wb_clk_i);
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL rd_done_pulses: got %0d required 1", done_cnt - d0); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rd_busy_after: got %b required 0", busy_o); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rd_left: got %0d required 0", exp_q.size()); end
    n_vec++; if (gap_viol != 0) begin n_err++; $display("FAIL stb_gap: got %0d required 0", gap_viol); end
  endtask

  task automatic test_wait_states();
    int x0, cycles; logic seen, bd;
    wait_states = 3; set_job(1'b1); push_job(20, 8);
    x0 = n_xfer;
    pulse_start();
    measure_writes(x0, cycles);
    n_vec++; if (cycles != 100) begin n_err++; $display("FAIL ws_cycles: got %0d required 100", cycles); end
    result_rdy_i = 1'b1;
    wait_done(seen, bd);
    result_rdy_i = 1'b0;
    wait_states = 0;
    repeat (3) @(negedge wb_clk_i);
    n_vec++; if (seen !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL ws_done: got done=%b left=%0d required done=1 left=0", seen, exp_q.size()); end
    n_vec++; if (hash_o !== exp_hash) begin n_err++; $display("FAIL ws_hash: got %h required %h", hash_o, exp_hash); end
  endtask

  task automatic test_timeout();
    int d0, stuck; logic seen, bd;
    set_job(1'b1); nack_en = 1'b1; push_job(5, 0);
    d0 = done_cnt; stuck = 0;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (err_o) break;
      if (bus.stb && bus.adr == BASE + 32'd20) stuck++;
      @(negedge wb_clk_i);
    end
    n_vec++; if (stuck != 255) begin n_err++; $display("FAIL to_stb_cycles: got %0d required 255", stuck); end
    n_vec++; if ({bus.cyc, bus.stb, busy_o, err_o} !== 4'b0001) begin n_err++; $display("FAIL to_state: got %b required 0001", {bus.cyc, bus.stb, busy_o, err_o}); end
    repeat (5) @(negedge wb_clk_i);
    n_vec++; if (done_cnt != d0 || exp_q.size() != 0) begin n_err++; $display("FAIL to_no_done: got done=%0d left=%0d required 0 0", done_cnt - d0, exp_q.size()); end
    nack_en = 1'b0; push_job(20, 8); result_rdy_i = 1'b1;
    pulse_start();
    n_vec++; if ({err_o, busy_o} !== 2'b01) begin n_err++; $display("FAIL to_restart: got err,busy=%b required 01", {err_o, busy_o}); end
    wait_done(seen, bd);
    result_rdy_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    n_vec++; if (seen !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL to_rerun: got done=%b left=%0d required done=1 left=0", seen, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int x0; logic seen, bd;
    set_job(1'b1); push_job(20, 8);
    x0 = n_xfer;
    pulse_start();
    for (int i = 0; i < 200 && !(bus.stb && bus.adr == BASE + 32'd40); i++) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    n_vec++; if ({bus.cyc, bus.stb, busy_o} !== 3'b000) begin n_err++; $display("FAIL rst_mid_bus: got %b required 000", {bus.cyc, bus.stb, busy_o}); end
    n_vec++; if (hash_o !== '0) begin n_err++; $display("FAIL rst_mid_hash: got %h required 0", hash_o); end
    n_vec++; if (n_xfer - x0 != 10) begin n_err++; $display("FAIL rst_mid_words: got %0d required 10", n_xfer - x0); end
    #1 wb_rst_i = 1'b0;
    exp_q.delete();
    @(negedge wb_clk_i);
    push_job(20, 8); result_rdy_i = 1'b1;
    pulse_start();
    wait_done(seen, bd);
    result_rdy_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    n_vec++; if (seen !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL rst_mid_rerun: got done=%b left=%0d required done=1 left=0", seen, exp_q.size()); end
    n_vec++; if (hash_o !== exp_hash) begin n_err++; $display("FAIL rst_mid_hash2: got %h required %h", hash_o, exp_hash); end
  endtask

  task automatic test_busy_stray();
    int x0, d0; logic seen, bd;
    set_job(1'b1); push_job(20, 8);
    x0 = n_xfer; d0 = done_cnt;
    pulse_start();
    for (int j = 0; j < 3; j++) begin
      repeat (5) @(negedge wb_clk_i);
      start_i = 1'b1; @(negedge wb_clk_i); start_i = 1'b0;
    end
    for (int i = 0; i < 500 && n_xfer != x0 + 20; i++) @(negedge wb_clk_i);
    repeat (3) @(negedge wb_clk_i);
    stray_ack = 1'b1; @(negedge wb_clk_i); stray_ack = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    n_vec++; if (n_xfer - x0 != 20) begin n_err++; $display("FAIL stray_writes: got %0d required 20", n_xfer - x0); end
    result_rdy_i = 1'b1;
    wait_done(seen, bd);
    result_rdy_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    n_vec++; if (n_xfer - x0 != 28 || exp_q.size() != 0) begin n_err++; $display("FAIL stray_total: got %0d left=%0d required 28 left=0", n_xfer - x0, exp_q.size()); end
    n_vec++; if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin n_err++; $display("FAIL stray_done: got pulses=%0d busy=%b required 1 0", done_cnt - d0, busy_o); end
    n_vec++; if (hash_o !== exp_hash) begin n_err++; $display("FAIL stray_hash: got %h required %h", hash_o, exp_hash); end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_busy_stray();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
